// File: rtl/dram_arbiter_pkg.sv
// Shared constants and helpers for the two-master data RAM arbiter.
// Master 0 is the CPU load/store unit and master 1 is the CNN accelerator.
package dram_arbiter_pkg;

  localparam logic MST_CPU        = 1'b0;
  localparam logic MST_CNN        = 1'b1;
  localparam int   STARVE_MAX_DEF = 4;

  // An all-zero byte strobe marks the access as a read.
  function automatic logic is_read(input logic [3:0] we);
    return (we == 4'b0000);
  endfunction

endpackage

// File: rtl/dram_arb_starve.sv
// CNN starvation counter. It raises force_m1 after STARVE_MAX denied
// request cycles in a row, so the next grant goes to the CNN.
module dram_arb_starve
  import dram_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m1_req,
  input  logic       m1_gnt,
  output logic [3:0] starve_cnt,
  output logic       force_m1
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!m1_req || m1_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign force_m1 = (starve_cnt == CNT_MAX);

endmodule

// File: rtl/dram_arbiter.sv
// Fixed-priority arbiter for the CPU and the CNN in front of the byte-lane
// data RAM. It also steers each one-cycle-late read response to its issuer.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic [3:0]    m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [3:0]    m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_en,
  output logic [3:0]    ram_wen,
  output logic          ram_ren,
  output logic [AW-1:0] ram_w_addr,
  output logic [AW-1:0] ram_r_addr,
  output logic [DW-1:0] ram_w_data,
  input  logic [DW-1:0] ram_r_data
);

  logic [3:0] starve_cnt;
  logic       force_m1;
  logic       rsp_valid;
  logic       rsp_sel;

  dram_arb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk        (clk),
    .rst        (rst),
    .m1_req     (m1_req),
    .m1_gnt     (m1_gnt),
    .starve_cnt (starve_cnt),
    .force_m1   (force_m1)
  );

  // Grants are gated by reset so that nothing reaches the RAM while the
  // response flops are being held clear.
  assign m0_gnt = rst & m0_req & ~force_m1;
  assign m1_gnt = rst & m1_req & (force_m1 | ~m0_req);

  always_comb begin
    ram_en     = 1'b0;
    ram_wen    = 4'b0000;
    ram_ren    = 1'b0;
    ram_w_addr = '0;
    ram_w_data = '0;
    if (m0_gnt) begin
      ram_en     = 1'b1;
      ram_wen    = m0_we;
      ram_ren    = is_read(m0_we);
      ram_w_addr = m0_addr;
      ram_w_data = m0_wdata;
    end else if (m1_gnt) begin
      ram_en     = 1'b1;
      ram_wen    = m1_we;
      ram_ren    = is_read(m1_we);
      ram_w_addr = m1_addr;
      ram_w_data = m1_wdata;
    end
  end

  assign ram_r_addr = ram_w_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_sel   <= MST_CPU;
    end else begin
      rsp_valid <= ram_ren;
      rsp_sel   <= m1_gnt ? MST_CNN : MST_CPU;
    end
  end

  assign m0_rvalid = rsp_valid & (rsp_sel == MST_CPU);
  assign m1_rvalid = rsp_valid & (rsp_sel == MST_CNN);
  assign m0_rdata  = m0_rvalid ? ram_r_data : '0;
  assign m1_rdata  = m1_rvalid ? ram_r_data : '0;

endmodule
